// File: rtl/wave_param_ctrl.sv
// rtl/wave_param_ctrl.sv - button-driven waveform/frequency/amplitude settings with valid/ready commit
module wave_param_ctrl #(
    parameter int unsigned              FREQ_W     = 32,
    parameter logic [FREQ_W-1:0]        FREQ_MIN   = FREQ_W'(32'd1),
    parameter logic [FREQ_W-1:0]        FREQ_MAX   = FREQ_W'(32'h0FFF_FFFF),
    parameter logic [FREQ_W-1:0]        FREQ_DEF   = FREQ_W'(32'd42950),
    parameter logic [FREQ_W-1:0]        FREQ_STEP  = FREQ_W'(32'd43),
    parameter int unsigned              STEP_SHIFT = 3,
    parameter int unsigned              AMP_W      = 8,
    parameter logic [AMP_W-1:0]         AMP_DEF    = AMP_W'(8'd128),
    parameter logic [AMP_W-1:0]         AMP_STEP   = AMP_W'(8'd16)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_mode_p,
    input  logic              btn_step_p,
    input  logic              btn_up_p,
    input  logic              btn_down_p,
    input  logic              upd_ready,
    output logic              upd_valid,
    output logic [1:0]        wave_sel,
    output logic [FREQ_W-1:0] freq_word,
    output logic [AMP_W-1:0]  amplitude,
    output logic [2:0]        field_sel,
    output logic [1:0]        step_idx
);

    localparam logic [2:0] FIELD_WAVE = 3'b001;
    localparam logic [2:0] FIELD_FREQ = 3'b010;
    localparam logic [2:0] FIELD_AMP  = 3'b100;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state_q;
    logic              dirty_q;
    logic              valid_q;
    logic [1:0]        wave_out_q;
    logic [FREQ_W-1:0] freq_out_q;
    logic [AMP_W-1:0]  amp_out_q;

    logic [1:0]        wave_w_q, wave_w_d;
    logic [FREQ_W-1:0] freq_w_q, freq_w_d;
    logic [AMP_W-1:0]  amp_w_q,  amp_w_d;
    logic [2:0]        field_q,  field_d;
    logic [1:0]        step_q,   step_d;

    logic              edit_en, edit_up, edit_dn;
    logic              load_out;
    logic [FREQ_W:0]   step_amt, freq_ext, freq_sum;
    logic [FREQ_W-1:0] freq_inc, freq_dec;
    logic [AMP_W:0]    amp_sum;
    logic [AMP_W-1:0]  amp_inc, amp_dec;

    // Mode beats step beats up/down; simultaneous up+down cancel.
    assign edit_en = ~btn_mode_p & ~btn_step_p & (btn_up_p ^ btn_down_p);
    assign edit_up = edit_en & btn_up_p;
    assign edit_dn = edit_en & btn_down_p;

    // Saturation compares are done one bit wider so neither bound can wrap.
    assign step_amt = {1'b0, FREQ_STEP} << (STEP_SHIFT * step_q);
    assign freq_ext = {1'b0, freq_w_q};
    assign freq_sum = freq_ext + step_amt;
    assign freq_inc = (freq_sum > {1'b0, FREQ_MAX}) ? FREQ_MAX : freq_sum[FREQ_W-1:0];
    assign freq_dec = (freq_ext < ({1'b0, FREQ_MIN} + step_amt)) ? FREQ_MIN
                                                                 : (freq_w_q - step_amt[FREQ_W-1:0]);

    assign amp_sum = {1'b0, amp_w_q} + {1'b0, AMP_STEP};
    assign amp_inc = amp_sum[AMP_W] ? {AMP_W{1'b1}} : amp_sum[AMP_W-1:0];
    assign amp_dec = (amp_w_q < AMP_STEP) ? {AMP_W{1'b0}} : (amp_w_q - AMP_STEP);

    always_comb begin
        wave_w_d = wave_w_q;
        freq_w_d = freq_w_q;
        amp_w_d  = amp_w_q;
        field_d  = field_q;
        step_d   = step_q;
        if (btn_mode_p) begin
            field_d = {field_q[1:0], field_q[2]};
        end else if (btn_step_p) begin
            step_d = step_q + 2'd1;
        end else if (edit_en) begin
            case (field_q)
                FIELD_WAVE: wave_w_d = edit_up ? (wave_w_q + 2'd1) : (wave_w_q - 2'd1);
                FIELD_FREQ: freq_w_d = edit_up ? freq_inc : freq_dec;
                FIELD_AMP:  amp_w_d  = edit_up ? amp_inc  : amp_dec;
                default:    ;
            endcase
        end
    end

    // Outputs are reloaded from the pre-edit working copy; a same-edge edit
    // re-arms dirty so it rides on the next copy.
    assign load_out = dirty_q & ((state_q == S_IDLE) | (valid_q & upd_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            dirty_q    <= 1'b1;
            valid_q    <= 1'b0;
            wave_out_q <= 2'd0;
            freq_out_q <= FREQ_DEF;
            amp_out_q  <= AMP_DEF;
            wave_w_q   <= 2'd0;
            freq_w_q   <= FREQ_DEF;
            amp_w_q    <= AMP_DEF;
            field_q    <= FIELD_WAVE;
            step_q     <= 2'd0;
        end else begin
            wave_w_q <= wave_w_d;
            freq_w_q <= freq_w_d;
            amp_w_q  <= amp_w_d;
            field_q  <= field_d;
            step_q   <= step_d;
            dirty_q  <= edit_en | (dirty_q & ~load_out);
            if (load_out) begin
                wave_out_q <= wave_w_q;
                freq_out_q <= freq_w_q;
                amp_out_q  <= amp_w_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (dirty_q) begin
                        valid_q <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (upd_ready && !dirty_q) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign upd_valid = valid_q;
    assign wave_sel  = wave_out_q;
    assign freq_word = freq_out_q;
    assign amplitude = amp_out_q;
    assign field_sel = field_q;
    assign step_idx  = step_q;

endmodule

// File: tb/tb_wave_param_ctrl.sv
// tb/tb_wave_param_ctrl.sv - self-checking bench for wave_param_ctrl
module tb_wave_param_ctrl;

    localparam longint FMIN = 1;
    localparam longint FMAX = 64'h0FFF_FFFF;
    localparam longint FDEF = 42950;
    localparam longint FSTP = 43;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        btn_mode_p = 1'b0, btn_step_p = 1'b0, btn_up_p = 1'b0, btn_down_p = 1'b0;
    logic        upd_ready = 1'b1;
    logic        upd_valid;
    logic [1:0]  wave_sel;
    logic [31:0] freq_word;
    logic [7:0]  amplitude;
    logic [2:0]  field_sel;
    logic [1:0]  step_idx;

    int total = 0;
    int bad = 0;

    wave_param_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .btn_mode_p(btn_mode_p), .btn_step_p(btn_step_p),
        .btn_up_p(btn_up_p), .btn_down_p(btn_down_p),
        .upd_ready(upd_ready), .upd_valid(upd_valid),
        .wave_sel(wave_sel), .freq_word(freq_word), .amplitude(amplitude),
        .field_sel(field_sel), .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    // Behavioural model: field index 0=wave 1=freq 2=amp.
    int     m_field = 0, m_step = 0, m_wave = 0, m_amp = 128;
    longint m_freq = FDEF;
    bit     m_dirty = 1, m_valid = 0;
    int     o_wave = 0, o_amp = 128;
    longint o_freq = FDEF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_field = 0; m_step = 0; m_wave = 0; m_freq = FDEF; m_amp = 128;
            m_dirty = 1; m_valid = 0; o_wave = 0; o_freq = FDEF; o_amp = 128;
        end else begin
            longint st;
            if (!m_valid || upd_ready) begin
                if (m_dirty) begin
                    o_wave = m_wave; o_freq = m_freq; o_amp = m_amp;
                    m_valid = 1; m_dirty = 0;
                end else begin
                    m_valid = 0;
                end
            end
            st = FSTP * (longint'(1) << (3 * m_step));
            if (btn_mode_p) m_field = (m_field + 1) % 3;
            else if (btn_step_p) m_step = (m_step + 1) % 4;
            else if (btn_up_p != btn_down_p) begin
                m_dirty = 1;
                if (m_field == 0) m_wave = btn_up_p ? (m_wave + 1) % 4 : (m_wave + 3) % 4;
                else if (m_field == 1) begin
                    if (btn_up_p) m_freq = (m_freq + st > FMAX) ? FMAX : m_freq + st;
                    else          m_freq = (m_freq - st < FMIN) ? FMIN : m_freq - st;
                end else begin
                    if (btn_up_p) m_amp = (m_amp + 16 > 255) ? 255 : m_amp + 16;
                    else          m_amp = (m_amp - 16 < 0) ? 0 : m_amp - 16;
                end
            end
        end
    end

    task automatic cmp(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("valid", upd_valid, m_valid);
        cmp("field_sel", field_sel, longint'(1) << m_field);
        cmp("step_idx", step_idx, m_step);
        if (m_valid) begin
            cmp("wave_sel", wave_sel, o_wave);
            cmp("freq_word", freq_word, o_freq);
            cmp("amplitude", amplitude, o_amp);
        end
    end

    task automatic pulse(input logic m, input logic s, input logic u, input logic d);
        @(negedge clk);
        btn_mode_p = m; btn_step_p = s; btn_up_p = u; btn_down_p = d;
        @(negedge clk);
        btn_mode_p = 0; btn_step_p = 0; btn_up_p = 0; btn_down_p = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        cmp("t1 valid", upd_valid, 1);
        cmp("t1 wave", wave_sel, 0);
        cmp("t1 freq", freq_word, 42950);
        cmp("t1 amp", amplitude, 128);
        @(negedge clk);
        cmp("t1 valid drop", upd_valid, 0);

        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        pulse(0, 0, 1, 0);
        idle(4);
        cmp("t2 freq", freq_word, 43036);
        cmp("t2 valid", upd_valid, 0);

        repeat (3) pulse(0, 1, 0, 0);
        cmp("t3 step", step_idx, 3);
        @(negedge clk);
        btn_up_p = 1;
        idle(12300);
        btn_up_p = 0;
        idle(4);
        cmp("t3 freq max", freq_word, 32'h0FFF_FFFF);

        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        cmp("t4 field", field_sel, 3'b001);
        pulse(0, 0, 0, 1);
        idle(3);
        cmp("t4 wave down", wave_sel, 3);
        pulse(0, 0, 1, 0);
        idle(3);
        cmp("t4 wave up", wave_sel, 0);

        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        cmp("t5 field", field_sel, 3'b100);
        repeat (9) pulse(0, 0, 1, 0);
        idle(4);
        cmp("t5 amp sat", amplitude, 255);
        pulse(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cmp("t5 no xfer", upd_valid, 0);
            @(negedge clk);
        end

        repeat (16) pulse(0, 0, 0, 1);
        repeat (8) pulse(0, 0, 1, 0);
        idle(4);
        cmp("t6 amp base", amplitude, 128);
        upd_ready = 0;
        pulse(0, 0, 1, 0);
        idle(1);
        cmp("t6 valid", upd_valid, 1);
        cmp("t6 amp 144", amplitude, 144);
        pulse(0, 0, 1, 0);
        idle(3);
        cmp("t6 amp hold", amplitude, 144);
        upd_ready = 1;
        @(negedge clk);
        cmp("t6 b2b valid", upd_valid, 1);
        cmp("t6 amp 160", amplitude, 160);
        @(negedge clk);
        cmp("t6 valid drop", upd_valid, 0);

        upd_ready = 0;
        pulse(0, 0, 1, 0);
        idle(2);
        cmp("t7 valid pre", upd_valid, 1);
        #2 rst_n = 1'b0;
        #1 cmp("t7 async drop", upd_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        upd_ready = 1;
        @(negedge clk);
        cmp("t7 valid", upd_valid, 1);
        cmp("t7 wave", wave_sel, 0);
        cmp("t7 freq", freq_word, 42950);
        cmp("t7 amp", amplitude, 128);
        cmp("t7 field", field_sel, 3'b001);
        cmp("t7 step", step_idx, 0);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
